pattern_recog_param: RTL and testbench
======================================

// Module: pattern_recog_param
// PURPOSE
//  Parametrised serial bit-pattern detector; generalises the fixed 7-bit FSM detector.
//  Pattern width is a parameter; pattern value and overlap mode are loaded at run time.
//  Gated by a valid strobe; flags every occurrence and counts matches (saturating).
//  Sits between a serial deserialiser/bit-sampler and control/status logic.
// PARAMETERS
//  PAT_W   7   pattern length in bits, >= 2
//  CNT_W   8   width of the match counter
// PORTS
//  clk         in   1      system clock, rising edge
//  rstn        in   1      asynchronous active-low reset
//  start       in   1      pulse: capture cfg_*, clear window, enter FILL
//  stop        in   1      pulse: return to IDLE; window cleared, counter kept
//  cnt_clr     in   1      pulse: zero match_cnt
//  cfg_pattern in   PAT_W  pattern; MSB = first bit received (1101011 -> 7'b1101011)
//  cfg_overlap in   1      1 = overlapping matches allowed, 0 = window restarts after a hit
//  din_valid   in   1      din qualifier; bits with din_valid=0 are ignored
//  din         in   1      serial data bit
//  match       out  1      one-cycle pulse per detected pattern
//  match_cnt   out  CNT_W  matches since last cnt_clr/reset, saturates at all-ones
//  busy        out  1      1 in FILL or HUNT
// BEHAVIOUR
//  Reset: state=IDLE, shift reg=0, fill_cnt=0, match=0, match_cnt=0, busy=0, shadow cfg=0.
//  FSM states:
//   IDLE: din ignored. start -> FILL.
//   FILL: fewer than PAT_W valid bits held. Goes to HUNT when the valid bit completing the window arrives.
//   HUNT: window full; each valid bit is compared.
//  Arrival of each valid bit:
//   sr <= {sr[PAT_W-2:0], din}; fill_cnt increments, saturating at PAT_W.
//  Compare:
//   Compared window is {sr[PAT_W-2:0], din}, evaluated only when din_valid=1 and fill_cnt >= PAT_W-1.
//   Hit: window == shadow pattern (masked when the option is enabled).
//   match is registered: it is high for the one cycle after the edge that samples the completing bit.
//  After a hit:
//   cfg_overlap=1: stay in HUNT; the suffix is reused (1011011 after 1011 hits twice).
//   cfg_overlap=0: fill_cnt <= 0 and state <= FILL; the next hit needs PAT_W new valid bits.
//  din_valid=0: sr, fill_cnt and state hold; match=0 on the next cycle.
//  Configuration:
//   cfg_* are sampled only on start; changes at other times have no effect.
//  start while busy: restart.
//   Shadow cfg reloaded, sr/fill_cnt cleared, state=FILL.
//   The bit presented in that cycle is discarded; no match is produced from it.
//  Control priority: start > stop.
//   stop in FILL/HUNT: -> IDLE; the bit in that cycle is discarded.
//  Counter:
//   match_cnt += 1 on each hit, holding at 2^CNT_W-1.
//   cnt_clr in the same cycle as a hit: counter = 0, and the match pulse is still issued.
//  busy is registered and mirrors state != IDLE.
// CONFIGURATION
//  PATDET_MASK_EN defined:
//   Adds input cfg_mask[PAT_W-1:0], captured on start; a 1 bit means care.
//   Hit condition: (window & mask) == (pattern & mask).
//   All-zero mask hits on every compared bit.
//  PATDET_MASK_EN undefined: no cfg_mask port; exact compare on all PAT_W bits.
// STRUCTURE
//  Package pattern_recog_pkg:
//   state enum encoding IDLE=2'd0, FILL=2'd1, HUNT=2'd2.
//   Defaults PAT_W_DEF=7 and CNT_W_DEF=8.
//  Sub-module sat_counter (width CNT_W: inc, clr, saturating) holds match_cnt.
//  FSM, shift register and compare stay in the top level.
// TESTING
//  1 Reset: rstn low mid-HUNT -> match=0, match_cnt=0, busy=0 immediately, async.
//  2 PAT_W=7, pattern 1101011, overlap=1, stream 1101011 -> one match pulse 1 cycle after 7th bit; match_cnt=1.
//  3 overlap=1, pattern 1011 (PAT_W=4), stream 1011011 -> matches after bits 4 and 7; cnt=2.
//    Same stream with overlap=0 -> 1 match.
//  4 din_valid gaps: 1101011 with din_valid=0 between every bit -> exactly 1 match.
//    cfg_pattern changed mid-stream -> no effect.
//  5 Saturation: CNT_W=2, 5 hits -> match_cnt=3; cnt_clr coincident with a hit -> match=1, cnt=0.
//  6 PATDET_MASK_EN: pattern 1101011, mask 1111100, stream 1101000 -> match.
//    start during HUNT -> window cleared; no match until PAT_W new bits.

Source files
------------

// File: rtl/pattern_recog_pkg.sv
// Shared types and defaults for the parametrised serial pattern detector.
//   state_t    : detector FSM encoding (IDLE/FILL/HUNT)
//   PAT_W_DEF  : default pattern length
//   CNT_W_DEF  : default match counter width
package pattern_recog_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

    localparam int PAT_W_DEF = 7;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/pattern_recog_param_if.sv
// Bus between a bit sampler / control block (master) and the pattern
// detector (slave).
//   start, stop, cnt_clr   : control pulses from master
//   cfg_pattern/overlap    : run-time configuration, sampled on start
//   cfg_mask               : care mask, only present with PATDET_MASK_EN
//   din_valid, din         : qualified serial bit stream
//   match, match_cnt, busy : detector status back to master
interface pattern_recog_param_if
    import pattern_recog_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic             stop;
    logic             cnt_clr;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
`ifdef PATDET_MASK_EN
    logic [PAT_W-1:0] cfg_mask;
`endif
    logic             din_valid;
    logic             din;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;

    modport master (
        output start, stop, cnt_clr, cfg_pattern, cfg_overlap,
`ifdef PATDET_MASK_EN
        output cfg_mask,
`endif
        output din_valid, din,
        input  match, match_cnt, busy
    );

    modport slave (
        input  start, stop, cnt_clr, cfg_pattern, cfg_overlap,
`ifdef PATDET_MASK_EN
        input  cfg_mask,
`endif
        input  din_valid, din,
        output match, match_cnt, busy
    );
endinterface

// File: rtl/pattern_recog_param_sat_counter.sv
// Saturating up-counter holding the detector match count.
//   clk, rstn : clock, async active-low reset
//   inc       : add one (ignored once at all-ones)
//   clr       : synchronous clear, wins over inc
//   count     : current value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end
endmodule

// File: rtl/pattern_recog_param.sv
// Parametrised serial bit-pattern detector.
// Shifts in qualified bits, compares the newest PAT_W bits against a pattern
// captured on start, pulses match for one cycle per hit and counts hits in a
// saturating counter. Overlapping hits are optional at run time.
// Ports:
//   clk   : system clock, rising edge
//   rstn  : asynchronous active-low reset
//   bus   : pattern_recog_param_if.slave (control, config, data, status)
// Build option:
//   PATDET_MASK_EN : adds cfg_mask (1 = care bit) to the compare; when
//                    undefined the compare is exact on all PAT_W bits.
//
// state | meaning
// IDLE  | stopped, din ignored
// FILL  | fewer than PAT_W valid bits held since start/last non-overlap hit
// HUNT  | window full, every valid bit is compared
module pattern_recog_param
    import pattern_recog_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    pattern_recog_param_if.slave bus
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    state_t            state;
    // Only the newest PAT_W-1 bits are ever needed: the incoming bit completes the window.
    logic [PAT_W-2:0]  sr;
    logic [FILL_W-1:0] fill_cnt;
    logic [PAT_W-1:0]  pat_q;
    logic              overlap_q;
`ifdef PATDET_MASK_EN
    logic [PAT_W-1:0]  mask_q;
`endif
    logic              match_q;
    logic              busy_q;

    logic [PAT_W-1:0]  window;
    logic              take_bit;
    logic              win_eq;
    logic              hit;

    assign window   = {sr, bus.din};
    // start and stop both discard the bit presented in their cycle.
    assign take_bit = (state != IDLE) && bus.din_valid && !bus.start && !bus.stop;
`ifdef PATDET_MASK_EN
    assign win_eq   = ((window ^ pat_q) & mask_q) == '0;
`else
    assign win_eq   = (window == pat_q);
`endif
    assign hit      = take_bit && (fill_cnt >= FILL_LAST) && win_eq;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            sr        <= '0;
            fill_cnt  <= '0;
            pat_q     <= '0;
            overlap_q <= 1'b0;
`ifdef PATDET_MASK_EN
            mask_q    <= '0;
`endif
            match_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            match_q <= hit;
            if (bus.start) begin
                pat_q     <= bus.cfg_pattern;
                overlap_q <= bus.cfg_overlap;
`ifdef PATDET_MASK_EN
                mask_q    <= bus.cfg_mask;
`endif
                sr        <= '0;
                fill_cnt  <= '0;
                state     <= FILL;
                busy_q    <= 1'b1;
            end else if (bus.stop) begin
                sr        <= '0;
                fill_cnt  <= '0;
                state     <= IDLE;
                busy_q    <= 1'b0;
            end else if (take_bit) begin
                sr <= window[PAT_W-2:0];
                if (hit && !overlap_q) begin
                    fill_cnt <= '0;
                    state    <= FILL;
                end else if (fill_cnt >= FILL_LAST) begin
                    fill_cnt <= FILL_FULL;
                    state    <= HUNT;
                end else begin
                    fill_cnt <= fill_cnt + FILL_W'(1);
                    state    <= FILL;
                end
            end
        end
    end

    assign bus.match = match_q;
    assign bus.busy  = busy_q;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (hit),
        .clr   (bus.cnt_clr),
        .count (bus.match_cnt)
    );
endmodule

// File: tb/tb_pattern_recog_param.sv
// Bench driving three detector builds with one shared stimulus stream:
//   A: PAT_W=7 CNT_W=8, B: PAT_W=4 CNT_W=8, C: PAT_W=3 CNT_W=2.
module tb_pattern_recog_param;

    localparam int PW [3] = '{7, 4, 3};
    localparam int CW [3] = '{8, 8, 2};

    logic clk;
    logic rstn;

    logic       st, sp, cc, ov, dv, d;
    logic [6:0] pat_a;
    logic [3:0] pat_b;
    logic [2:0] pat_c;
`ifdef PATDET_MASK_EN
    logic [6:0] mask_a;
    logic [3:0] mask_b;
    logic [2:0] mask_c;
`endif

    int tests = 0;
    int fails = 0;
    int n_a, n_b, n_c;

    // reference model state: last bits seen since the window last restarted
    int m_active [3];
    int m_bits   [3];
    int m_hist   [3];
    int m_pat    [3];
    int m_mask   [3];
    int m_ov     [3];
    int m_cnt    [3];
    int m_match  [3];

    pattern_recog_param_if #(.PAT_W(7), .CNT_W(8)) if_a ();
    pattern_recog_param_if #(.PAT_W(4), .CNT_W(8)) if_b ();
    pattern_recog_param_if #(.PAT_W(3), .CNT_W(2)) if_c ();

    pattern_recog_param #(.PAT_W(7), .CNT_W(8)) dut_a (.clk(clk), .rstn(rstn), .bus(if_a));
    pattern_recog_param #(.PAT_W(4), .CNT_W(8)) dut_b (.clk(clk), .rstn(rstn), .bus(if_b));
    pattern_recog_param #(.PAT_W(3), .CNT_W(2)) dut_c (.clk(clk), .rstn(rstn), .bus(if_c));

    assign if_a.start = st;  assign if_b.start = st;  assign if_c.start = st;
    assign if_a.stop = sp;   assign if_b.stop = sp;   assign if_c.stop = sp;
    assign if_a.cnt_clr = cc; assign if_b.cnt_clr = cc; assign if_c.cnt_clr = cc;
    assign if_a.cfg_overlap = ov; assign if_b.cfg_overlap = ov; assign if_c.cfg_overlap = ov;
    assign if_a.din_valid = dv; assign if_b.din_valid = dv; assign if_c.din_valid = dv;
    assign if_a.din = d;     assign if_b.din = d;     assign if_c.din = d;
    assign if_a.cfg_pattern = pat_a;
    assign if_b.cfg_pattern = pat_b;
    assign if_c.cfg_pattern = pat_c;
`ifdef PATDET_MASK_EN
    assign if_a.cfg_mask = mask_a;
    assign if_b.cfg_mask = mask_b;
    assign if_c.cfg_mask = mask_c;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic st, sp, dv, d;
        int   em, ecnt, ebusy;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cfg_pat(input int k);
        case (k)
            0:       return int'(pat_a);
            1:       return int'(pat_b);
            default: return int'(pat_c);
        endcase
    endfunction

    function automatic int cfg_msk(input int k);
`ifdef PATDET_MASK_EN
        case (k)
            0:       return int'(mask_a);
            1:       return int'(mask_b);
            default: return int'(mask_c);
        endcase
`else
        return (1 << PW[k]) - 1;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_active[k] = 0; m_bits[k] = 0; m_hist[k] = 0; m_pat[k] = 0;
            m_mask[k] = 0; m_ov[k] = 0; m_cnt[k] = 0; m_match[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int wm;
            int hit;
            wm  = (1 << PW[k]) - 1;
            hit = 0;
            if (st) begin
                m_active[k] = 1;
                m_pat[k]    = cfg_pat(k);
                m_mask[k]   = cfg_msk(k);
                m_ov[k]     = int'(ov);
                m_bits[k]   = 0;
                m_hist[k]   = 0;
            end else if (sp) begin
                m_active[k] = 0;
                m_bits[k]   = 0;
            end else if (m_active[k] != 0 && dv) begin
                m_hist[k] = ((m_hist[k] << 1) | int'(d)) & wm;
                m_bits[k]++;
                if (m_bits[k] >= PW[k] && (((m_hist[k] ^ m_pat[k]) & m_mask[k] & wm) == 0)) begin
                    hit = 1;
                    if (m_ov[k] == 0) m_bits[k] = 0;
                end
            end
            m_match[k] = hit;
            if (cc) m_cnt[k] = 0;
            else if (hit != 0 && m_cnt[k] < (1 << CW[k]) - 1) m_cnt[k]++;
        end
    endtask

    // one clock: model predicts, DUTs clock, all outputs compared 1 ns later
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("match_a", int'(if_a.match), m_match[0]);
        chk("cnt_a",   int'(if_a.match_cnt), m_cnt[0]);
        chk("busy_a",  int'(if_a.busy), m_active[0]);
        chk("match_b", int'(if_b.match), m_match[1]);
        chk("cnt_b",   int'(if_b.match_cnt), m_cnt[1]);
        chk("busy_b",  int'(if_b.busy), m_active[1]);
        chk("match_c", int'(if_c.match), m_match[2]);
        chk("cnt_c",   int'(if_c.match_cnt), m_cnt[2]);
        chk("busy_c",  int'(if_c.busy), m_active[2]);
        if (if_a.match) n_a++;
        if (if_b.match) n_b++;
        if (if_c.match) n_c++;
    endtask

    task automatic idle_inputs();
        st = 0; sp = 0; cc = 0; dv = 0; d = 0;
    endtask

    task automatic bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            idle_inputs();
            dv = 1; d = v[i];
            cyc();
        end
    endtask

    task automatic begin_run(input logic ovl);
        idle_inputs();
        st = 1; cc = 1; ov = ovl;
        cyc();
        idle_inputs();
        n_a = 0; n_b = 0; n_c = 0;
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        ov = 1; pat_a = '0; pat_b = '0; pat_c = '0;
`ifdef PATDET_MASK_EN
        mask_a = '1; mask_b = '1; mask_c = '1;
`endif
        model_reset();
        n_a = 0; n_b = 0; n_c = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_match_a", int'(if_a.match), 0);
        chk("rst_cnt_a",   int'(if_a.match_cnt), 0);
        chk("rst_busy_a",  int'(if_a.busy), 0);
        chk("rst_busy_c",  int'(if_c.busy), 0);
        rstn = 1'b1;

        // pattern 1101011, overlap on, single clean occurrence
        pat_a = 7'b1101011; pat_b = 4'b1011; pat_c = 3'b101; ov = 1;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 0};
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            st = tbl[i].st; sp = tbl[i].sp; dv = tbl[i].dv; d = tbl[i].d;
            cyc();
            chk($sformatf("tbl%0d_match", i), int'(if_a.match), tbl[i].em);
            chk($sformatf("tbl%0d_cnt", i),   int'(if_a.match_cnt), tbl[i].ecnt);
            chk($sformatf("tbl%0d_busy", i),  int'(if_a.busy), tbl[i].ebusy);
        end

        // 1011 over 1011011: two hits with overlap, one without
        pat_b = 4'b1011;
        begin_run(1'b1);
        bits(16'b1011011, 7);
        chk("ovl_hits_b", n_b, 2);
        chk("ovl_cnt_b", int'(if_b.match_cnt), 2);
        begin_run(1'b0);
        bits(16'b1011011, 7);
        chk("novl_hits_b", n_b, 1);

        // valid gaps between every bit, pattern input disturbed mid-stream
        pat_a = 7'b1101011;
        begin_run(1'b1);
        for (int i = 6; i >= 0; i--) begin
            logic [6:0] s;
            s = 7'b1101011;
            idle_inputs(); dv = 1; d = s[i]; cyc();
            idle_inputs(); d = 1'($urandom_range(0, 1)); cyc();
            if (i == 3) pat_a = 7'b0000000;
        end
        chk("gap_hits_a", n_a, 1);
        chk("gap_cnt_a", int'(if_a.match_cnt), 1);

        // saturation of a 2-bit counter, then clear coincident with a hit
        pat_c = 3'b101;
        begin_run(1'b1);
        bits(16'b10101010101, 11);
        chk("sat_hits_c", n_c, 5);
        chk("sat_cnt_c", int'(if_c.match_cnt), 3);
        bits(16'b0, 1);
        idle_inputs(); dv = 1; d = 1; cc = 1; cyc();
        chk("clr_hit_match_c", int'(if_c.match), 1);
        chk("clr_hit_cnt_c", int'(if_c.match_cnt), 0);

        // restart while hunting: old window must not complete a match
        pat_a = 7'b1101011;
        begin_run(1'b1);
        bits(16'b11010111, 8);
        chk("pre_restart_hits_a", n_a, 1);
        idle_inputs(); st = 1; dv = 1; d = 1; cyc();
        idle_inputs();
        n_a = 0;
        bits(16'b101011, 6);
        chk("restart_no_hit_a", n_a, 0);
        bits(16'b1101011, 7);
        chk("restart_new_hit_a", n_a, 1);

`ifdef PATDET_MASK_EN
        pat_a = 7'b1101011; mask_a = 7'b1111100;
        begin_run(1'b1);
        bits(16'b1101000, 7);
        chk("mask_hit_a", n_a, 1);
        mask_a = '1;
`endif

        // randomized traffic against the model
        idle_inputs(); st = 1; ov = 1; cyc();
        for (int i = 0; i < 1500; i++) begin
            st = ($urandom_range(0, 39) == 0);
            sp = ($urandom_range(0, 79) == 0);
            cc = ($urandom_range(0, 59) == 0);
            dv = ($urandom_range(0, 9) < 7);
            d  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                ov    = 1'($urandom_range(0, 1));
                pat_a = 7'($urandom);
                pat_b = 4'($urandom);
                pat_c = 3'($urandom);
`ifdef PATDET_MASK_EN
                mask_a = 7'($urandom);
                mask_b = 4'($urandom);
                mask_c = 3'($urandom);
`endif
            end
            cyc();
        end

        // asynchronous reset while A is hunting with a match pulse out
        pat_a = 7'b1101011; pat_b = 4'b1011; pat_c = 3'b011;
`ifdef PATDET_MASK_EN
        mask_a = '1; mask_b = '1; mask_c = '1;
`endif
        begin_run(1'b1);
        bits(16'b1101011, 7);
        chk("pre_rst_match_a", int'(if_a.match), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_match_a", int'(if_a.match), 0);
        chk("async_cnt_a",   int'(if_a.match_cnt), 0);
        chk("async_busy_a",  int'(if_a.busy), 0);
        chk("async_cnt_b",   int'(if_b.match_cnt), 0);
        chk("async_busy_c",  int'(if_c.busy), 0);
        #20;
        rstn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
